// File: rtl/rdcla_arbiter.sv
// rtl/rdcla_arbiter.sv - two-requester round-robin arbiter in front of a shared pipelined 32-bit adder
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/ready         request handshake (N = 0, 1); ready is combinational
//   reqN_a, reqN_b, reqN_sub operands and op (0 = a+b, 1 = a-b)
//   add_a, add_b, add_cin    registered operands to the external adder
//   add_sum, add_cout        adder result, LATENCY edges after operands change
//   respN_valid/sum/cout     one-cycle response pulse with held result data
//   idle                     high when no operation is outstanding for either requester
module rdcla_arbiter #(
  parameter int LATENCY = 6,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic        add_cout,
  output logic        resp0_valid,
  output logic [31:0] resp0_sum,
  output logic        resp0_cout,
  output logic        resp1_valid,
  output logic [31:0] resp1_sum,
  output logic        resp1_cout,
  output logic        idle
);

  localparam int CW = 4;

  logic [CW-1:0]  cnt0;
  logic [CW-1:0]  cnt1;
  logic           last_grant;
  logic [LATENCY:0] tag_v;
  logic [LATENCY:0] tag_id;

  logic        elig0, elig1;
  logic        want0, want1;
  logic        grant0, grant1;
  logic        acc0, acc1, acc;
  logic [31:0] sel_a, sel_b;
  logic        sel_sub;
  logic        resp_hit, resp_id;
  logic        dec0, dec1;

  always_comb begin
    elig0  = cnt0 < CW'(MAX_OUT);
    elig1  = cnt1 < CW'(MAX_OUT);
    want0  = req0_valid & elig0;
    want1  = req1_valid & elig1;
    // Contention goes to whoever did not win the previous acceptance.
    grant0 = want0 & (~want1 | last_grant);
    grant1 = want1 & (~want0 | ~last_grant);
    req0_ready = grant0 & ~rst;
    req1_ready = grant1 & ~rst;
    acc0   = req0_valid & req0_ready;
    acc1   = req1_valid & req1_ready;
    acc    = acc0 | acc1;
    sel_a   = acc1 ? req1_a   : req0_a;
    sel_b   = acc1 ? req1_b   : req0_b;
    sel_sub = acc1 ? req1_sub : req0_sub;
    // The tag at the deepest stage lines up with the adder output of that op.
    resp_hit = tag_v[LATENCY];
    resp_id  = tag_id[LATENCY];
    dec0 = resp_hit & ~resp_id;
    dec1 = resp_hit & resp_id;
    idle = (cnt0 == '0) && (cnt1 == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a       <= '0;
      add_b       <= '0;
      add_cin     <= 1'b0;
      last_grant  <= 1'b1;
      tag_v       <= '0;
      tag_id      <= '0;
      cnt0        <= '0;
      cnt1        <= '0;
      resp0_valid <= 1'b0;
      resp0_sum   <= '0;
      resp0_cout  <= 1'b0;
      resp1_valid <= 1'b0;
      resp1_sum   <= '0;
      resp1_cout  <= 1'b0;
    end else begin
      if (acc) begin
        add_a      <= sel_a;
        // Subtraction as a + ~b + 1, so cout = 1 means no borrow.
        add_b      <= sel_sub ? ~sel_b : sel_b;
        add_cin    <= sel_sub;
        last_grant <= acc1;
      end
      tag_v  <= {tag_v[LATENCY-1:0], acc};
      tag_id <= {tag_id[LATENCY-1:0], acc1};

      resp0_valid <= dec0;
      resp1_valid <= dec1;
      if (dec0) begin
        resp0_sum  <= add_sum;
        resp0_cout <= add_cout;
      end
      if (dec1) begin
        resp1_sum  <= add_sum;
        resp1_cout <= add_cout;
      end

      cnt0 <= cnt0 + CW'(acc0) - CW'(dec0);
      cnt1 <= cnt1 + CW'(acc1) - CW'(dec1);
    end
  end

endmodule

// File: tb/tb_rdcla_arbiter.sv
// tb/tb_rdcla_arbiter.sv - scoreboard bench for rdcla_arbiter with a behavioural pipelined adder
module tb_rdcla_arbiter;
  localparam int LATENCY = 6;
  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        resp0_valid, resp1_valid, resp0_cout, resp1_cout;
  logic [31:0] resp0_sum, resp1_sum;
  logic        idle;

  rdcla_arbiter #(.LATENCY(LATENCY), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .resp0_valid(resp0_valid), .resp0_sum(resp0_sum), .resp0_cout(resp0_cout),
    .resp1_valid(resp1_valid), .resp1_sum(resp1_sum), .resp1_cout(resp1_cout),
    .idle(idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  // Shared adder: LATENCY register stages behind the operand registers.
  logic [32:0] pipe [LATENCY];
  always_ff @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign add_sum  = pipe[LATENCY-1][31:0];
  assign add_cout = pipe[LATENCY-1][32];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s, input int due);
    exp_t e;
    logic [32:0] w;
    if (s) begin
      e.sum  = a - b;
      e.cout = (a >= b);
    end else begin
      w      = {1'b0, a} + {1'b0, b};
      e.sum  = w[31:0];
      e.cout = w[32];
    end
    e.due = due;
    return e;
  endfunction

  // Scoreboard monitor: retires responses, checks ready/idle, then records acceptances.
  exp_t me;
  bit   m_last;
  bit   m_e0, m_e1, m_g0, m_g1;
  initial begin
    m_last = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        q0.delete();
        q1.delete();
        m_last = 1'b1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_idle", idle, 1);
        chk("rst_resp_valid", {resp0_valid, resp1_valid}, 0);
      end else begin
        if (resp0_valid) begin
          if (q0.size() == 0) chk("resp0_unexpected", 1, 0);
          else begin
            me = q0.pop_front();
            chk("resp0_sum", resp0_sum, me.sum);
            chk("resp0_cout", resp0_cout, me.cout);
            chk("resp0_cycle", cyc, me.due);
          end
        end
        if (resp1_valid) begin
          if (q1.size() == 0) chk("resp1_unexpected", 1, 0);
          else begin
            me = q1.pop_front();
            chk("resp1_sum", resp1_sum, me.sum);
            chk("resp1_cout", resp1_cout, me.cout);
            chk("resp1_cycle", cyc, me.due);
          end
        end
        if (resp0_valid || resp1_valid) chk("resp_exclusive", resp0_valid && resp1_valid, 0);
        m_e0 = req0_valid && (q0.size() < MAX_OUT);
        m_e1 = req1_valid && (q1.size() < MAX_OUT);
        m_g0 = m_e0 && (!m_e1 || m_last);
        m_g1 = m_e1 && (!m_e0 || !m_last);
        chk("ready0", req0_ready, m_g0);
        chk("ready1", req1_ready, m_g1);
        chk("idle", idle, (q0.size() == 0) && (q1.size() == 0));
        // Acceptance happens at the next edge (cyc+1); response visible here LATENCY+1 edges later.
        if (req0_valid && req0_ready) begin
          q0.push_back(model(req0_a, req0_b, req0_sub, cyc + LATENCY + 2));
          m_last = 1'b0;
        end else if (req1_valid && req1_ready) begin
          q1.push_back(model(req1_a, req1_b, req1_sub, cyc + LATENCY + 2));
          m_last = 1'b1;
        end
      end
    end
  end

  task automatic send(input int id, input logic [31:0] a, input logic [31:0] b, input logic s);
    bit done = 0;
    @(posedge clk); #1;
    if (id == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_sub = s; end
    else         begin req1_valid = 1; req1_a = a; req1_b = b; req1_sub = s; end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) done = 1;
    end
    if (!done) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", (q0.size() == 0) && (q1.size() == 0), 1);
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic rand_op(input int id);
    if (id == 0) begin req0_a = $urandom; req0_b = $urandom; req0_sub = 1'($urandom_range(0, 1)); end
    else         begin req1_a = $urandom; req1_b = $urandom; req1_sub = 1'($urandom_range(0, 1)); end
  endtask

  logic [11:0] pat;

  task automatic stream(input bit en0, input bit en1, input int cycles);
    bit a0, a1;
    bit turn = 0;
    pat = '0;
    req0_valid = en0;
    req1_valid = en1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (i < 12) pat[i] = a0;
      if (en0 && en1) begin
        chk("rr_one_grant", {a0, a1}, turn ? 2'b01 : 2'b10);
        turn = !turn;
      end
      @(posedge clk); #1;
      if (a0) rand_op(0);
      if (a1) rand_op(1);
    end
    req0_valid = 0;
    req1_valid = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);
    chk("rst_resp_sums", {resp0_sum, resp1_sum}, 0);
    chk("rst_resp_couts", {resp0_cout, resp1_cout}, 0);
    @(posedge clk); #1;
    rst = 0;

    send(0, 32'h5, 32'h3, 0);
    drain();
    send(1, 32'd5, 32'd7, 1);
    send(1, 32'd7, 32'd5, 1);
    drain();
    send(0, 32'hFFFFFFFF, 32'h1, 0);
    drain();
    for (int i = 0; i < 6; i++) send(i % 2, $urandom, $urandom, 1'($urandom_range(0, 1)));
    drain();

    // Both requesters streaming from reset.
    @(posedge clk); #1;
    rst = 1;
    rand_op(0);
    rand_op(1);
    req0_valid = 1;
    req1_valid = 1;
    @(posedge clk); #1;
    rst = 0;
    stream(1, 1, 24);
    drain();

    // One requester saturating its outstanding limit.
    rand_op(0);
    stream(1, 0, 24);
    chk("sat_pattern", pat, 12'b1111_0000_1111);
    drain();

    // Reset while three operations are in flight.
    send(0, $urandom, $urandom, 0);
    send(1, $urandom, $urandom, 1);
    send(0, $urandom, $urandom, 1);
    @(posedge clk); #1;
    rst = 1;
    rand_op(0);
    req0_valid = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_idle", idle, 1);
    chk("post_rst_ready0", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    drain();
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rdcla_arbiter.md
RDCLA_ARBITER -- requirements
Module: rdcla_arbiter

Interface
REQ-001 The block SHALL have parameter LATENCY, default 6, the pipelined 32-bit adder latency in clock edges from operand presentation to result.
REQ-002 The block SHALL have parameter MAX_OUT, default 4, the maximum outstanding operations per requester (range 1..15).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  input  1  clock; all state changes on rising edge.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Ports: reqN_valid  input  1, reqN_ready  output  1, reqN_a  input  32, reqN_b  input  32, reqN_sub  input  1 (N = 0, 1); request channel: operands and op (0 = a+b, 1 = a-b).
REQ-007 Ports: add_a  output  32, add_b  output  32, add_cin  output  1; registered operands to the shared adder.
REQ-008 Ports: add_sum  input  32, add_cout  input  1; adder result.
REQ-009 Ports: respN_valid  output  1, respN_sum  output  32, respN_cout  output  1 (N = 0, 1); response channel, no backpressure.
REQ-010 Port: idle  output  1; high when nothing is in flight and no response is pending.

Function
REQ-011 A request SHALL be accepted on a rising edge where reqN_valid and reqN_ready are both high; at most one acceptance per cycle.
REQ-012 reqN_ready SHALL be combinational: high only if requester N is eligible (outstanding count < MAX_OUT) and wins arbitration this cycle.
REQ-013 Arbitration SHALL be round-robin: if both requesters are valid and eligible, the grant goes to the one not granted at the last acceptance; after reset, requester 0 has priority.
REQ-014 If only one requester is valid and eligible, it SHALL be granted regardless of pointer; the pointer updates only on acceptance.
REQ-015 On acceptance, add_a <= a; for add, add_b <= b and add_cin <= 0; for sub, add_b <= ~b and add_cin <= 1.
REQ-016 On cycles with no acceptance, add_a, add_b and add_cin SHALL hold their values; results from those cycles are ignored.
REQ-017 A LATENCY-deep tag shift register (valid bit, requester id) SHALL track each accepted operation in lockstep with the adder pipeline.
REQ-018 When the tag at depth LATENCY is valid, the block SHALL register add_sum/add_cout into respN_sum/respN_cout of the tagged requester and pulse respN_valid for one cycle.
REQ-019 Total latency: respN_valid SHALL be high in the cycle following the (LATENCY+1)-th rising edge after the acceptance edge.
REQ-020 respN_sum/respN_cout SHALL hold their last values when respN_valid is low; both responses are never valid in the same cycle.
REQ-021 Per-requester outstanding counters SHALL increment on acceptance and decrement on response; simultaneous acceptance and response leaves the count unchanged.
REQ-022 Responses SHALL return in acceptance order; back-to-back acceptances yield back-to-back responses.
REQ-023 idle SHALL equal: both counters zero.
REQ-024 All arithmetic is modulo 2^32; cout is the adder carry-out (for sub, 1 means no borrow).

Reset
REQ-025 While rst is high: all respN_valid = 0, respN_sum = 0, respN_cout = 0, add_a = add_b = 0, add_cin = 0, tag valid bits cleared, counters zero, round-robin pointer favours requester 0, idle = 1, reqN_ready = 0.
REQ-026 Reset mid-operation SHALL discard all in-flight operations; no response for them is ever produced after reset deasserts.
REQ-027 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-028 req0 add a=0x00000005 b=0x00000003 -> resp0_valid one cycle, 7 cycles after acceptance edge (LATENCY=6), resp0_sum=0x00000008, resp0_cout=0.
REQ-029 req1 sub a=5 b=7 -> resp1_sum=0xFFFFFFFE, resp1_cout=0; then sub a=7 b=5 -> resp1_sum=0x00000002, resp1_cout=1.
REQ-030 req0 add a=0xFFFFFFFF b=0x00000001 -> resp0_sum=0x00000000, resp0_cout=1.
REQ-031 Both requesters valid continuously from reset -> acceptance order 0,1,0,1,...; responses alternate resp0/resp1 on consecutive cycles.
REQ-032 req0 valid continuously, req1 idle -> 4 back-to-back acceptances, req0_ready low until first resp0_valid, then one acceptance per response with count held at 4.
REQ-033 Three operations in flight, rst pulsed one cycle -> no respN_valid ever follows; idle=1 and reqN_ready high on the first cycle after rst deasserts.
